l0_skew_fifo: RTL

- Parametrised successor to the L0 input buffer in the corelet.
- Holds ROW independent FIFO lanes of BW bits each, all written together from the activation SRAM path.
- Feeds the mac_array west edge (in_w).
- Adds configurable depth, overflow/underflow status, and a skewed read mode: lane k pops k cycles after lane 0, so the systolic diagonal skew is generated in hardware instead of by the instruction stream.

---
 rtl/l0_skew_fifo_if.sv | 31 +++
 rtl/l0_skew_fifo.sv | 112 +++++++++++
 2 files changed

// File: rtl/l0_skew_fifo_if.sv
// Bus bundle for the L0 skew FIFO: write/read controls from the SRAM and
// sequencer side, plus the per-lane read data and status toward mac_array.
interface l0_skew_fifo_if #(
    parameter int bw  = 4,
    parameter int row = 8
);
    logic [row*bw-1:0] in;
    logic              wr;
    logic              rd;
    logic              mode;
    logic [row*bw-1:0] out;
    logic [row-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic              o_busy;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output in, wr, rd, mode,
        input  out, o_valid, o_full, o_ready, o_empty, o_busy,
               o_overflow, o_underflow
    );

    modport slave (
        input  in, wr, rd, mode,
        output out, o_valid, o_full, o_ready, o_empty, o_busy,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/l0_skew_fifo.sv
// L0 skew FIFO: row independent lanes written together, read either all at
// once (mode 0) or along the systolic diagonal (mode 1, lane k pops k cycles
// after lane 0). Requires row >= 2 and depth a power of two >= 2.
module l0_skew_fifo #(
    parameter int bw    = 4,
    parameter int row   = 8,
    parameter int depth = 16
) (
    input logic          clk,
    input logic          reset,
    l0_skew_fifo_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

    // Storage is not reset; pointers alone define which entries are live.
    logic [bw-1:0] mem_r [row][depth];
    // Pointers carry one extra wrap bit above the index.
    logic [aw:0]   rd_ptr_r [row];
    logic [aw:0]   wr_ptr_r [row];
    logic [row-1:1] skew_sr_r;
    logic [row*bw-1:0] out_r;
    logic [row-1:0] valid_r;
    logic          overflow_r;
    logic          underflow_r;

    logic [row-1:0] lane_empty_s;
    logic [row-1:0] lane_full_s;
    logic [row-1:0] req_s;
    logic [row-1:0] pop_s;
    logic           full_s;
    logic           push_s;

    // Lane status from registered pointers, lane requests and accepted push/pops.
    always_comb begin
        lane_empty_s = '0;
        lane_full_s  = '0;
        req_s        = '0;
        for (int k = 0; k < row; k++) begin
            lane_empty_s[k] = (rd_ptr_r[k] == wr_ptr_r[k]);
            lane_full_s[k]  = (rd_ptr_r[k][aw-1:0] == wr_ptr_r[k][aw-1:0]) &&
                              (rd_ptr_r[k][aw] != wr_ptr_r[k][aw]);
        end
        req_s[0] = bus.rd;
        for (int k = 1; k < row; k++) begin
            // Mode 0 broadcasts the read; in-flight skewed requests always issue.
            req_s[k] = (bus.rd & ~bus.mode) | skew_sr_r[k];
        end
        pop_s  = req_s & ~lane_empty_s;
        full_s = |lane_full_s;
        // A write is refused whenever any lane is full, even if it pops now.
        push_s = bus.wr & ~full_s;
    end

    // Lane storage write: every lane takes its slice at its write pointer.
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int k = 0; k < row; k++) begin
                mem_r[k][wr_ptr_r[k][aw-1:0]] <= bus.in[k*bw +: bw];
            end
        end else begin
            for (int k = 0; k < row; k++) begin
                mem_r[k][wr_ptr_r[k][aw-1:0]] <= mem_r[k][wr_ptr_r[k][aw-1:0]];
            end
        end
    end

    // Pointers, skew pipeline, registered read data/valid and sticky status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < row; k++) begin
                rd_ptr_r[k] <= '0;
                wr_ptr_r[k] <= '0;
            end
            skew_sr_r   <= '0;
            out_r       <= '0;
            valid_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            skew_sr_r[1] <= bus.rd & bus.mode;
            for (int k = 2; k < row; k++) begin
                skew_sr_r[k] <= skew_sr_r[k-1];
            end
            for (int k = 0; k < row; k++) begin
                if (push_s) begin
                    wr_ptr_r[k] <= wr_ptr_r[k] + ptr_one;
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k]        <= rd_ptr_r[k] + ptr_one;
                    out_r[k*bw +: bw]  <= mem_r[k][rd_ptr_r[k][aw-1:0]];
                end
            end
            valid_r <= pop_s;
            if (bus.wr && full_s) begin
                overflow_r <= 1'b1;
            end
            if (|(req_s & lane_empty_s)) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign bus.out         = out_r;
    assign bus.o_valid     = valid_r;
    assign bus.o_full      = full_s;
    assign bus.o_ready     = ~full_s;
    assign bus.o_empty     = &lane_empty_s;
    assign bus.o_busy      = |skew_sr_r;
    assign bus.o_overflow  = overflow_r;
    assign bus.o_underflow = underflow_r;
endmodule
